// File: rtl/wishbone_plic_pkg.sv
// rtl/wishbone_plic_pkg.sv - register map constants and ID type for the platform interrupt controller
package wishbone_plic_pkg;

    localparam logic [31:0] PLIC_START         = 32'h0000_0000;
    localparam logic [31:0] PLIC_SIZE          = 32'h0000_0100;

    localparam logic [31:0] PLIC_PENDING       = 32'h00;
    localparam logic [31:0] PLIC_ENABLE        = 32'h04;
    localparam logic [31:0] PLIC_MODE          = 32'h08;
    localparam logic [31:0] PLIC_CLAIM         = 32'h0C;
    localparam logic [31:0] PLIC_THRESHOLD     = 32'h10;
    localparam logic [31:0] PLIC_PRIORITY_BASE = 32'h40;

    typedef logic [4:0] plic_id_t;

endpackage

// File: rtl/wishbone_plic_priority_select.sv
// rtl/wishbone_plic_priority_select.sv - combinational tournament tree picking the winning interrupt ID
module plic_priority_select
    import wishbone_plic_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int PRIO_WIDTH  = 3
) (
    input  logic [NUM_SOURCES-1:0]            eligible,
    input  logic [NUM_SOURCES*PRIO_WIDTH-1:0] priorities,
    output plic_id_t                          id,
    output logic                              valid
);

    logic [31:0]              elig_pad;
    logic [32*PRIO_WIDTH-1:0] prio_pad;

    assign elig_pad = 32'(eligible);
    assign prio_pad = (32*PRIO_WIDTH)'(priorities);

    // Heap-indexed tree: leaves 32..63, root 1. Left child always holds the lower ID,
    // so it keeps the slot unless the right child is strictly higher priority.
    function automatic plic_id_t select_winner(input logic [31:0] e, input logic [32*PRIO_WIDTH-1:0] p);
        logic                  v  [64];
        logic [PRIO_WIDTH-1:0] pr [64];
        plic_id_t              d  [64];
        v[0]  = 1'b0;
        pr[0] = '0;
        d[0]  = '0;
        for (int i = 0; i < 32; i++) begin
            v[32+i]  = e[i];
            pr[32+i] = p[i*PRIO_WIDTH +: PRIO_WIDTH];
            d[32+i]  = plic_id_t'(i + 1);
        end
        for (int n = 31; n >= 1; n--) begin
            if (v[2*n+1] && (!v[2*n] || pr[2*n+1] > pr[2*n])) begin
                v[n] = 1'b1;  pr[n] = pr[2*n+1];  d[n] = d[2*n+1];
            end else begin
                v[n] = v[2*n]; pr[n] = pr[2*n];   d[n] = d[2*n];
            end
        end
        return v[1] ? d[1] : '0;
    endfunction

    assign id    = select_winner(elig_pad, prio_pad);
    assign valid = (id != '0);

endmodule

// File: rtl/wishbone_plic.sv
// rtl/wishbone_plic.sv - bus-mapped interrupt controller with claim/complete; priorities under WISHBONE_PLIC_PRIORITY_EN
module wishbone_plic
    import wishbone_plic_pkg::*;
#(
    parameter logic [31:0] ADDRESS     = PLIC_START,
    parameter logic [31:0] SIZE        = PLIC_SIZE,
    parameter int          NUM_SOURCES = 8,
    parameter int          PRIO_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] sources,
    output logic                   interrupt,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic                   we,
    input  logic [31:0]            adr,
    input  logic [3:0]             sel,
    input  logic [31:0]            dat_mosi,
    output logic [31:0]            dat_miso,
    output logic                   ack,
    output logic                   stall
);

    logic [NUM_SOURCES-1:0]            pending, pending_next, enable, mode, prev;
    logic [NUM_SOURCES-1:0]            eligible, claim_mask, w1c;
    logic [NUM_SOURCES*PRIO_WIDTH-1:0] prio_flat;
    plic_id_t                          in_service, in_service_next, win_id, claim_id;
    logic                              win_valid, access, in_win, claim_take, complete;
    logic                              hit_pending, hit_enable, hit_mode, hit_claim;
    logic [31:0]                       off, word, rdata;
    logic                              unused_ok;

    assign stall       = 1'b0;
    assign access      = cyc & stb;
    assign off         = adr - ADDRESS;
    assign word        = {off[31:2], 2'b00};
    assign in_win      = off < SIZE;
    assign hit_pending = in_win && (word == PLIC_PENDING);
    assign hit_enable  = in_win && (word == PLIC_ENABLE);
    assign hit_mode    = in_win && (word == PLIC_MODE);
    assign hit_claim   = in_win && (word == PLIC_CLAIM);
    assign unused_ok   = ^{sel, off[1:0]};

`ifdef WISHBONE_PLIC_PRIORITY_EN
    logic [PRIO_WIDTH-1:0] prio [NUM_SOURCES];
    logic [PRIO_WIDTH-1:0] threshold;
    logic                  hit_threshold, hit_prio;
    logic [31:0]           prio_idx;

    assign hit_threshold = in_win && (word == PLIC_THRESHOLD);
    assign hit_prio      = in_win && (word >= PLIC_PRIORITY_BASE) &&
                           (word < PLIC_PRIORITY_BASE + 32'(4*NUM_SOURCES));
    assign prio_idx      = (word - PLIC_PRIORITY_BASE) >> 2;

    always_comb begin
        prio_flat = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            prio_flat[i*PRIO_WIDTH +: PRIO_WIDTH] = prio[i];
            eligible[i] = pending[i] & enable[i] & (prio[i] > threshold) &
                          (in_service != plic_id_t'(i + 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            threshold <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) prio[i] <= '0;
        end else if (access && we) begin
            if (hit_threshold) threshold <= dat_mosi[PRIO_WIDTH-1:0];
            for (int i = 0; i < NUM_SOURCES; i++)
                if (hit_prio && prio_idx == 32'(i)) prio[i] <= dat_mosi[PRIO_WIDTH-1:0];
        end
    end
`else
    // Equal priorities everywhere make the tree fall back to lowest-ID-wins.
    always_comb begin
        prio_flat = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            eligible[i] = pending[i] & enable[i] & (in_service != plic_id_t'(i + 1));
    end
`endif

    plic_priority_select #(.NUM_SOURCES(NUM_SOURCES), .PRIO_WIDTH(PRIO_WIDTH)) u_select (
        .eligible   (eligible),
        .priorities (prio_flat),
        .id         (win_id),
        .valid      (win_valid)
    );

    assign claim_id   = (in_service == '0 && win_valid) ? win_id : '0;
    assign claim_take = access & ~we & hit_claim & (claim_id != '0);
    assign complete   = access & we & hit_claim & (in_service != '0) & (dat_mosi == 32'(in_service));
    assign w1c        = (access && we && hit_pending) ? dat_mosi[NUM_SOURCES:1] : '0;

    // Edge sets are OR'd in last so a fresh edge survives a same-cycle claim or W1C.
    always_comb begin
        claim_mask   = '0;
        pending_next = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            claim_mask[i]   = claim_take && (win_id == plic_id_t'(i + 1));
            pending_next[i] = mode[i] ? ((pending[i] & ~claim_mask[i] & ~w1c[i]) | (sources[i] & ~prev[i]))
                                      : sources[i];
        end
    end

    always_comb begin
        in_service_next = in_service;
        if (complete)        in_service_next = '0;
        else if (claim_take) in_service_next = win_id;
    end

    always_comb begin
        rdata = '0;
        if (hit_pending)     rdata = 32'({pending, 1'b0});
        else if (hit_enable) rdata = 32'({enable, 1'b0});
        else if (hit_mode)   rdata = 32'({mode, 1'b0});
        else if (hit_claim)  rdata = 32'(claim_id);
`ifdef WISHBONE_PLIC_PRIORITY_EN
        if (hit_threshold) rdata = 32'(threshold);
        for (int i = 0; i < NUM_SOURCES; i++)
            if (hit_prio && prio_idx == 32'(i)) rdata = 32'(prio[i]);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            enable     <= '0;
            mode       <= '0;
            prev       <= '0;
            in_service <= '0;
            interrupt  <= 1'b0;
            ack        <= 1'b0;
            dat_miso   <= '0;
        end else begin
            prev       <= sources;
            pending    <= pending_next;
            in_service <= in_service_next;
            // Looks at the post-claim slot so the request drops on the same edge as the claim.
            interrupt  <= win_valid && (in_service_next == '0);
            ack        <= access;
            dat_miso   <= (access && !we) ? rdata : '0;
            if (access && we && hit_enable) enable <= dat_mosi[NUM_SOURCES:1];
            if (access && we && hit_mode)   mode   <= dat_mosi[NUM_SOURCES:1];
        end
    end

endmodule

// File: doc/wishbone_plic.md
Name: wishbone_plic

Overview:
- Parametrised platform interrupt controller on the memory-bus interconnect; replaces the fixed OR of peripheral interrupts that drives the CPU external interrupt input.
- Aggregates NUM_SOURCES interrupt lines with per-source enable, edge/level mode and priority.
- Claim/complete handshake with one in-service slot; single registered interrupt output to the CPU.

Parameters:
- ADDRESS, 32'h0, base byte address of the register window
- SIZE, 32'h100, window size in bytes
- NUM_SOURCES, 8, number of interrupt sources (1..31); source IDs are 1..NUM_SOURCES, ID 0 means "none"
- PRIO_WIDTH, 3, width of each priority and of the threshold

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- sources  input  NUM_SOURCES  interrupt lines, already synchronous to clk; bit i-1 is source ID i
- interrupt  output  1  registered request to the CPU external interrupt input
- wishbone  interface  -  wishbone_interface.slave

Behaviour:
- Register map, word offsets from ADDRESS; sel ignored; 32-bit accesses only:
  - 0x00 PENDING: read gives pending bits (bit i = ID i, bit 0 reads 0); write-1-to-clear, edge sources only.
  - 0x04 ENABLE: RW, reset 0.
  - 0x08 MODE: RW, 1 = edge, 0 = level; reset 0.
  - 0x0C CLAIM: read claims; write completes.
  - 0x10 THRESHOLD: RW, reset 0.
  - 0x40+4*(ID-1) PRIORITY[ID]: RW, reset 0.
- Bus response: ack exactly one cycle after an accepted cyc&stb; stall always 0. Unmapped offsets read 0, ignore writes, still ack.
- Edge source: pending set on 0->1 of sources (previous-value register). Cleared by a successful claim or by W1C.
- Level source: pending tracks sources[i] each cycle. Claim sets in_service but does not force the level low.
- Eligible(i) = pending & enable & (priority > threshold) & ~in_service(i).
- Selection: the highest priority among eligible sources wins. On a priority tie, the lower ID wins. Priority 0 is never eligible.
- interrupt is registered: it rises 1 cycle after an eligible source exists and falls 1 cycle after none exists. interrupt is 0 while any claim is outstanding.
- CLAIM read returns the winning ID, sampled in the cycle the access is accepted, or 0 if there is none. In the same cycle:
  - set in_service for that ID;
  - clear pending for an edge source.
- A CLAIM read returning 0 has no side effects.
- CLAIM write of an ID equal to the in_service ID clears in_service. Any other ID is ignored.
- At most one in_service ID at a time. A second CLAIM read while one is outstanding returns 0.
- Simultaneous edge set and claim clear on the same source in the same cycle: set wins.
- Simultaneous edge set and W1C on the same source in the same cycle: set wins.
- Reset (async assert, sync release): all registers, pending, in_service and the edge history go to 0. Outputs: interrupt = 0, ack = 0, dat_miso = 0.
- Reset in the middle of a bus cycle drops ack. The access is lost.

Optional Feature:
- Macro: WISHBONE_PLIC_PRIORITY_EN.
- Defined: PRIORITY and THRESHOLD registers as above.
- Undefined:
  - no priority/threshold storage; PRIORITY and THRESHOLD read 0 and ignore writes;
  - eligibility = pending & enable & ~in_service;
  - the lowest eligible ID wins.

Decomposition:
- constants package gains:
  - PLIC_START and PLIC_SIZE;
  - register offset localparams (PLIC_PENDING, PLIC_ENABLE, PLIC_MODE, PLIC_CLAIM, PLIC_THRESHOLD, PLIC_PRIORITY_BASE);
  - typedef plic_id_t (5 bits).
- One sub-module, plic_priority_select: combinational reduction tree. Inputs are the eligible vector and the priority array; outputs are the winning ID and a valid flag.

Test Plan:
- Reset: drive rst=0 mid-operation with pending set -> interrupt=0; all registers read 0 after release.
- Edge source: ENABLE=0x2, MODE=0x2, PRIORITY[1]=3; pulse sources[0] for 1 cycle -> PENDING=0x2 and interrupt=1 after 1 cycle. CLAIM read -> 1, PENDING=0, interrupt=0. CLAIM write 1 -> in_service cleared.
- Priority/tie (macro defined): IDs 2 and 5 pending at priorities 2 and 6 -> CLAIM=5. Set both to 4 -> CLAIM=2. THRESHOLD=4 -> CLAIM=0, interrupt=0.
- Level source: ID 3 level, held high; claim -> 3. Complete while still high -> interrupt reasserts after 1 cycle. Drop the line -> PENDING bit 3=0.
- Nested claim / bad complete: claim ID 1 while ID 4 is also pending -> second CLAIM read returns 0. CLAIM write 4 -> ignored, in_service stays 1.
- Macro undefined: IDs 6 and 2 pending, PRIORITY[6] written 7 -> reads 0, CLAIM=2.
